// File: rtl/memwb_reg_pkg.sv
// Shared widths, reset constants and the MEM/WB field bundle for the memwb_reg pipeline register.
package memwb_reg_pkg;

  localparam int ALUOP_BUS      = 8;
  localparam int REG_ADDR_BUS   = 5;
  localparam int REG_BUS        = 32;
  localparam int DATA_BUS       = 32;
  localparam int INST_ADDR_BUS  = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam int DATA_WE_BUS    = 4;

  localparam logic [INST_ADDR_BUS-1:0] PC_INIT   = 32'hBFC0_0000;
  localparam logic [REG_BUS-1:0]       ZERO_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [ALUOP_BUS-1:0]      aluop;
    logic [REG_ADDR_BUS-1:0]   wa;
    logic                      wreg;
    logic                      whilo;
    logic                      mreg;
    logic [REG_BUS-1:0]        dreg;
    logic [DOUBLE_REG_BUS-1:0] dhilo;
    logic [DATA_WE_BUS-1:0]    dre;
    logic [INST_ADDR_BUS-1:0]  pc;
    logic                      cp0_we;
    logic [REG_ADDR_BUS-1:0]   cp0_waddr;
    logic [REG_BUS-1:0]        cp0_wdata;
    logic                      valid;
  } wb_fields_t;

  // A bubble writes nothing: every enable is zero and the pc parks at the reset vector.
  function automatic wb_fields_t bubble_fields();
    wb_fields_t f;
    f    = '0;
    f.pc = PC_INIT;
    return f;
  endfunction

endpackage

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register with stall/flush handling and an optional data-SRAM word hold path.
// Define MEMWB_DM_HOLD_EN to build the fresh/dm_hold logic; otherwise dm_o passes dm_i straight through.
module memwb_reg
  import memwb_reg_pkg::*;
(
  input  logic                      cpu_clk_50M,
  input  logic                      cpu_rst,
  input  logic [ALUOP_BUS-1:0]      mem_aluop,
  input  logic [REG_ADDR_BUS-1:0]   mem_wa,
  input  logic                      mem_wreg,
  input  logic                      mem_whilo,
  input  logic                      mem_mreg,
  input  logic [REG_BUS-1:0]        mem_dreg,
  input  logic [DOUBLE_REG_BUS-1:0] mem_dhilo,
  input  logic [DATA_WE_BUS-1:0]    mem_dre,
  input  logic [INST_ADDR_BUS-1:0]  mem_pc,
  input  logic                      mem_cp0_we,
  input  logic [REG_ADDR_BUS-1:0]   mem_cp0_waddr,
  input  logic [REG_BUS-1:0]        mem_cp0_wdata,
  input  logic                      stall_mem,
  input  logic                      stall_wb,
  input  logic                      flush,
  input  logic [DATA_BUS-1:0]       dm_i,
  output logic [ALUOP_BUS-1:0]      wb_aluop,
  output logic [REG_ADDR_BUS-1:0]   wb_wa,
  output logic                      wb_wreg,
  output logic                      wb_whilo,
  output logic                      wb_mreg,
  output logic [REG_BUS-1:0]        wb_dreg,
  output logic [DOUBLE_REG_BUS-1:0] wb_dhilo,
  output logic [DATA_WE_BUS-1:0]    wb_dre,
  output logic [INST_ADDR_BUS-1:0]  wb_pc,
  output logic                      wb_cp0_we,
  output logic [REG_ADDR_BUS-1:0]   wb_cp0_waddr,
  output logic [REG_BUS-1:0]        wb_cp0_wdata,
  output logic                      wb_valid,
  output logic [DATA_BUS-1:0]       dm_o
);

  wb_fields_t wb_q;
  wb_fields_t next_q;
  wb_fields_t mem_fields;
  logic       load_new;

  always_comb begin
    mem_fields           = '0;
    mem_fields.aluop     = mem_aluop;
    mem_fields.wa        = mem_wa;
    mem_fields.wreg      = mem_wreg;
    mem_fields.whilo     = mem_whilo;
    mem_fields.mreg      = mem_mreg;
    mem_fields.dreg      = mem_dreg;
    mem_fields.dhilo     = mem_dhilo;
    mem_fields.dre       = mem_dre;
    mem_fields.pc        = mem_pc;
    mem_fields.cp0_we    = mem_cp0_we;
    mem_fields.cp0_waddr = mem_cp0_waddr;
    mem_fields.cp0_wdata = mem_cp0_wdata;
    mem_fields.valid     = 1'b1;
  end

  // Flush beats a WB hold (an exception kills a held instruction); a WB hold beats a MEM bubble.
  always_comb begin
    next_q   = wb_q;
    load_new = 1'b0;
    if (flush) begin
      next_q = bubble_fields();
    end else if (stall_wb) begin
      next_q = wb_q;
    end else if (stall_mem) begin
      next_q = bubble_fields();
    end else begin
      next_q   = mem_fields;
      load_new = 1'b1;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      wb_q <= bubble_fields();
    end else begin
      wb_q <= next_q;
    end
  end

  assign wb_aluop     = wb_q.aluop;
  assign wb_wa        = wb_q.wa;
  assign wb_wreg      = wb_q.wreg;
  assign wb_whilo     = wb_q.whilo;
  assign wb_mreg      = wb_q.mreg;
  assign wb_dreg      = wb_q.dreg;
  assign wb_dhilo     = wb_q.dhilo;
  assign wb_dre       = wb_q.dre;
  assign wb_pc        = wb_q.pc;
  assign wb_cp0_we    = wb_q.cp0_we;
  assign wb_cp0_waddr = wb_q.cp0_waddr;
  assign wb_cp0_wdata = wb_q.cp0_wdata;
  assign wb_valid     = wb_q.valid;

`ifdef MEMWB_DM_HOLD_EN
  // The SRAM word is only valid in a load's first WB cycle; capture it then so stalls can't lose it.
  logic                fresh;
  logic [DATA_BUS-1:0] dm_hold;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      fresh   <= 1'b0;
      dm_hold <= ZERO_WORD;
    end else begin
      fresh <= load_new;
      if (fresh) begin
        dm_hold <= dm_i;
      end
    end
  end

  assign dm_o = fresh ? dm_i : dm_hold;
`else
  assign dm_o = dm_i;
`endif

endmodule
